// File: rtl/unary_stream_decoder_pkg.sv
// Shared types for the unary stream decoder: FSM states, frame length helper
// and the per-lane result record held in the output buffer.
package unary_pkg;

  localparam int DATA_W = 4;

  typedef enum logic {
    IDLE,
    COLLECT
  } state_t;

  function automatic int frame_len(input int size);
    return (1 << size) + 2;
  endfunction

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              sat;
    logic              terr;
  } lane_result_t;

endpackage

// File: rtl/unary_lane_counter.sv
// One lane of the decoder: counts ones over a frame, tracks thermometer order
// and converts the count (including the current cycle's bit) to signed binary.
module unary_lane_counter #(
  parameter int BIT_WIDTH = 4,
  parameter int SIZE      = BIT_WIDTH - 1,
  parameter int FRAME_LEN = (1 << SIZE) + 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clear,
  input  logic                 sample_en,
  input  logic                 unary_bit,
  input  logic                 sign,
  output logic [BIT_WIDTH-1:0] value,
  output logic                 sat,
  output logic                 terr
);

  localparam int CW = $clog2(FRAME_LEN + 1);
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [31:0] MAX_POS = 32'((1 << SIZE) - 1);
  localparam logic [31:0] MAX_NEG = 32'(1 << SIZE);

  logic [CW-1:0] cnt_q, cnt_next;
  logic          zero_q, zero_next;
  logic          terr_q, terr_next;
  logic          sign_q, sign_next;
  logic [31:0]   cnt_wide;
  logic [31:0]   mag;

  // Cycle 0 of a frame restarts the lane and still counts its own sample.
  always_comb begin
    cnt_next  = cnt_q;
    zero_next = zero_q;
    terr_next = terr_q;
    sign_next = sign_q;
    if (clear) begin
      cnt_next  = {{(CW-1){1'b0}}, unary_bit};
      zero_next = !unary_bit;
      terr_next = 1'b0;
      sign_next = sign;
    end else if (sample_en) begin
      if (unary_bit && cnt_q != CNT_MAX) cnt_next = cnt_q + CW'(1);
      if (unary_bit && zero_q) terr_next = 1'b1;
      if (!unary_bit) zero_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      zero_q <= 1'b0;
      terr_q <= 1'b0;
      sign_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_next;
      zero_q <= zero_next;
      terr_q <= terr_next;
      sign_q <= sign_next;
    end
  end

  assign cnt_wide = 32'(cnt_next);
  assign terr     = terr_next;

  // Negative values reach one step further than positive ones.
  always_comb begin
    value = '0;
    sat   = 1'b0;
    mag   = cnt_wide;
    if (sign_next) begin
      if (cnt_wide > MAX_NEG) begin
        mag = MAX_NEG;
        sat = 1'b1;
      end
      value = BIT_WIDTH'(32'd0 - mag);
    end else begin
      if (cnt_wide > MAX_POS) begin
        mag = MAX_POS;
        sat = 1'b1;
      end
      value = BIT_WIDTH'(mag);
    end
  end

endmodule

// File: rtl/unary_stream_decoder.sv
// Frame sequencing, per-lane counters and a two-entry result buffer with a
// valid/ready handshake for reading unary streams back into binary.
module unary_stream_decoder
  import unary_pkg::*;
#(
  parameter int LANES     = 4,
  parameter int BIT_WIDTH = DATA_W,
  parameter int SIZE      = BIT_WIDTH - 1,
  parameter int FRAME_LEN = frame_len(SIZE)
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       frame_start,
  input  logic [LANES-1:0]           unary_in,
  input  logic [LANES-1:0]           sign_in,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [LANES*BIT_WIDTH-1:0] out_data,
  output logic [LANES-1:0]           out_sat,
  output logic [LANES-1:0]           out_terr,
  output logic                       frame_err,
  output logic                       overrun
);

  localparam int PW = $clog2(FRAME_LEN);

  state_t        state, state_next;
  logic [PW-1:0] phase, phase_next;
  logic          clear, sample_en, commit, abort, pop;

  lane_result_t  lane_res [LANES];
  lane_result_t  head [LANES];
  lane_result_t  skid [LANES];
  logic          head_valid, skid_valid;

  // The frame_start cycle itself is phase 0, so the register holds phase 1.. onward.
  always_comb begin
    state_next = state;
    phase_next = phase;
    clear      = 1'b0;
    sample_en  = 1'b0;
    commit     = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (frame_start) begin
          clear      = 1'b1;
          state_next = COLLECT;
          phase_next = PW'(1);
        end
      end
      COLLECT: begin
        if (frame_start) begin
          abort      = 1'b1;
          clear      = 1'b1;
          phase_next = PW'(1);
        end else begin
          sample_en = 1'b1;
          if (phase == PW'(FRAME_LEN - 1)) begin
            commit     = 1'b1;
            state_next = IDLE;
            phase_next = '0;
          end else begin
            phase_next = phase + PW'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      phase <= '0;
    end else begin
      state <= state_next;
      phase <= phase_next;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [BIT_WIDTH-1:0] lane_value;
    logic                 lane_sat;
    logic                 lane_terr;

    unary_lane_counter #(
      .BIT_WIDTH (BIT_WIDTH),
      .SIZE      (SIZE),
      .FRAME_LEN (FRAME_LEN)
    ) u_counter (
      .clk       (clk),
      .reset_n   (reset_n),
      .clear     (clear),
      .sample_en (sample_en),
      .unary_bit (unary_in[i]),
      .sign      (sign_in[i]),
      .value     (lane_value),
      .sat       (lane_sat),
      .terr      (lane_terr)
    );

    assign lane_res[i] = '{data: lane_value, sat: lane_sat, terr: lane_terr};
  end

  assign pop = head_valid && out_ready;

  // Skid always holds the younger result, so a simultaneous pop shifts it forward.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_valid <= 1'b0;
      skid_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        head[i] <= '0;
        skid[i] <= '0;
      end
    end else begin
      frame_err <= abort;
      overrun   <= 1'b0;
      if (commit) begin
        if (!head_valid) begin
          head       <= lane_res;
          head_valid <= 1'b1;
        end else if (pop) begin
          if (skid_valid) begin
            head <= skid;
            skid <= lane_res;
          end else begin
            head <= lane_res;
          end
        end else if (!skid_valid) begin
          skid       <= lane_res;
          skid_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (pop) begin
        if (skid_valid) begin
          head       <= skid;
          skid_valid <= 1'b0;
        end else begin
          head_valid <= 1'b0;
        end
      end
    end
  end

  assign out_valid = head_valid;

  always_comb begin
    out_data = '0;
    out_sat  = '0;
    out_terr = '0;
    for (int i = 0; i < LANES; i++) begin
      out_data[i*BIT_WIDTH +: BIT_WIDTH] = head[i].data;
      out_sat[i]                         = head[i].sat;
      out_terr[i]                        = head[i].terr;
    end
  end

endmodule

// File: tb/tb_unary_stream_decoder.sv
// Directed bench for unary_stream_decoder: table of single-frame decodes plus
// hand-written backpressure, restart and reset sequences.
module tb_unary_stream_decoder;

  localparam int LANES = 4;
  localparam int BW    = 4;
  localparam int FL    = 10;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          frame_start;
  logic [3:0]    unary_in;
  logic [3:0]    sign_in;
  logic          out_ready;
  logic          out_valid;
  logic [15:0]   out_data;
  logic [3:0]    out_sat;
  logic [3:0]    out_terr;
  logic          frame_err;
  logic          overrun;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  sign;
    logic [15:0] counts;
    logic [3:0]  viol;
    logic [15:0] exp_data;
    logic [3:0]  exp_sat;
    logic [3:0]  exp_terr;
  } vec_t;

  vec_t vecs [5];

  unary_stream_decoder #(
    .LANES     (LANES),
    .BIT_WIDTH (BW)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .frame_start (frame_start),
    .unary_in    (unary_in),
    .sign_in     (sign_in),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_sat     (out_sat),
    .out_terr    (out_terr),
    .frame_err   (frame_err),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Lane l gets counts[l] leading ones; a violating lane swaps one 1 past a 0.
  function automatic logic [39:0] build_frame(input logic [15:0] counts,
                                              input logic [3:0] viol);
    logic [39:0] bits;
    bits = '0;
    for (int l = 0; l < 4; l++) begin
      int k;
      k = int'(counts[l*4 +: 4]);
      for (int c = 0; c < FL; c++)
        bits[c*4 + l] = viol[l] ? ((c < k - 1) || (c == k)) : (c < k);
    end
    return bits;
  endfunction

  task automatic apply_stimulus(input logic [39:0] bits, input logic [3:0] signs,
                                input logic pop_last);
    for (int c = 0; c < FL; c++) begin
      @(negedge clk);
      frame_start = (c == 0);
      unary_in    = bits[c*4 +: 4];
      sign_in     = signs;
      if (c == FL - 1) out_ready = pop_last;
    end
  endtask

  initial begin
    vecs[0] = '{4'b0000, 16'h0003, 4'b0000, 16'h0003, 4'b0000, 4'b0000};
    vecs[1] = '{4'b0110, 16'h9080, 4'b0000, 16'h7080, 4'b1000, 4'b0000};
    vecs[2] = '{4'b1011, 16'hA719, 4'b0000, 16'h87F8, 4'b1001, 4'b0000};
    vecs[3] = '{4'b0010, 16'h733A, 4'b0100, 16'h73D7, 4'b0001, 4'b0100};
    vecs[4] = '{4'b0101, 16'h1257, 4'b0000, 16'h1E59, 4'b0000, 4'b0000};

    reset_n     = 1'b0;
    frame_start = 1'b0;
    unary_in    = '0;
    sign_in     = '0;
    out_ready   = 1'b0;
    repeat (2) @(negedge clk);
    check_output("reset_valid", 32'(out_valid), 32'd0);
    check_output("reset_data", 32'(out_data), 32'd0);
    check_output("reset_flags", 32'({out_sat, out_terr, frame_err, overrun}), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      apply_stimulus(build_frame(vecs[v].counts, vecs[v].viol), vecs[v].sign, 1'b0);
      @(negedge clk);
      frame_start = 1'b0;
      unary_in    = '0;
      check_output($sformatf("vec%0d_valid", v), 32'(out_valid), 32'd1);
      check_output($sformatf("vec%0d_data", v), 32'(out_data), 32'(vecs[v].exp_data));
      check_output($sformatf("vec%0d_sat", v), 32'(out_sat), 32'(vecs[v].exp_sat));
      check_output($sformatf("vec%0d_terr", v), 32'(out_terr), 32'(vecs[v].exp_terr));
      check_output($sformatf("vec%0d_pulses", v), 32'({frame_err, overrun}), 32'd0);
      out_ready = 1'b1;
      @(negedge clk);
      check_output($sformatf("vec%0d_popped", v), 32'(out_valid), 32'd0);
      out_ready = 1'b0;
    end

    // Backpressure: three back-to-back frames, the third must be dropped.
    apply_stimulus(build_frame(16'h0003, 4'b0), 4'b0, 1'b0);
    apply_stimulus(build_frame(16'h0005, 4'b0), 4'b0, 1'b0);
    apply_stimulus(build_frame(16'h0007, 4'b0), 4'b0, 1'b0);
    @(negedge clk);
    frame_start = 1'b0;
    unary_in    = '0;
    check_output("bp_valid", 32'(out_valid), 32'd1);
    check_output("bp_head", 32'(out_data), 32'h0003);
    check_output("bp_overrun", 32'(overrun), 32'd1);
    @(negedge clk);
    check_output("bp_overrun_clear", 32'(overrun), 32'd0);
    check_output("bp_head_stable", 32'(out_data), 32'h0003);
    out_ready = 1'b1;
    @(negedge clk);
    check_output("bp_skid_valid", 32'(out_valid), 32'd1);
    check_output("bp_skid", 32'(out_data), 32'h0005);
    @(negedge clk);
    check_output("bp_empty", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // Commit and pop on the same edge.
    apply_stimulus(build_frame(16'h0003, 4'b0), 4'b0, 1'b0);
    apply_stimulus(build_frame(16'h0005, 4'b0), 4'b0, 1'b1);
    @(negedge clk);
    frame_start = 1'b0;
    unary_in    = '0;
    check_output("cp_data", 32'(out_data), 32'h0005);
    check_output("cp_overrun", 32'(overrun), 32'd0);
    @(negedge clk);
    check_output("cp_empty", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // Early restart at phase 4.
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      frame_start = (c == 0);
      unary_in    = 4'hF;
      sign_in     = 4'b0;
    end
    begin
      logic [39:0] bits;
      bits = build_frame(16'h0002, 4'b0);
      for (int c = 0; c < FL; c++) begin
        @(negedge clk);
        if (c == 1) check_output("er_frame_err", 32'(frame_err), 32'd1);
        if (c == 2) check_output("er_frame_err_clear", 32'(frame_err), 32'd0);
        if (c == FL - 1) check_output("er_no_stale", 32'(out_valid), 32'd0);
        frame_start = (c == 0);
        unary_in    = bits[c*4 +: 4];
      end
    end
    @(negedge clk);
    frame_start = 1'b0;
    unary_in    = '0;
    check_output("er_valid", 32'(out_valid), 32'd1);
    check_output("er_data", 32'(out_data), 32'h0002);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Reset mid-frame with a result sitting in the head.
    apply_stimulus(build_frame(16'h0003, 4'b0), 4'b0, 1'b0);
    @(negedge clk);
    frame_start = 1'b0;
    check_output("rst_pre_valid", 32'(out_valid), 32'd1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      frame_start = (c == 0);
      unary_in    = 4'hF;
    end
    @(negedge clk);
    frame_start = 1'b0;
    reset_n     = 1'b0;
    #1;
    check_output("rst_mid_valid", 32'(out_valid), 32'd0);
    check_output("rst_mid_data", 32'(out_data), 32'd0);
    @(negedge clk);
    reset_n  = 1'b1;
    unary_in = '0;
    repeat (12) @(negedge clk);
    check_output("rst_no_stale", 32'(out_valid), 32'd0);
    apply_stimulus(build_frame(16'h0040, 4'b0), 4'b0010, 1'b0);
    @(negedge clk);
    frame_start = 1'b0;
    unary_in    = '0;
    check_output("rst_post_valid", 32'(out_valid), 32'd1);
    check_output("rst_post_data", 32'(out_data), 32'h00C0);
    check_output("rst_post_flags", 32'({out_sat, out_terr}), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
